// File: rtl/spi_slave_if.sv
// SPI slave front end: 10-bit command words in on MOSI, read byte out on MISO (MSB first).
// rx_valid one cycle after the 10th word bit; MISO bit7 one cycle after tx_valid; no backpressure, SS_n high aborts.
module spi_slave_if #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int TXC_W = $clog2(DATA_W + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0]   shreg_q, shreg_d;
    logic                word_done_q, word_done_d;
    logic                tx_started_q, tx_started_d;
    logic [DATA_W-2:0]   tx_shreg_q, tx_shreg_d;
    logic [TXC_W-1:0]    tx_cnt_q, tx_cnt_d;
    logic [WORD_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                miso_q, miso_d;
    logic                rd_addr_seen_q, rd_addr_seen_d;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        word_done_d    = word_done_q;
        tx_started_d   = tx_started_q;
        tx_shreg_d     = tx_shreg_q;
        tx_cnt_d       = tx_cnt_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = miso_q;
        rd_addr_seen_d = rd_addr_seen_q;

        case (state_q)
            IDLE: begin
                if (!SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                bit_cnt_d    = '0;
                word_done_d  = 1'b0;
                tx_started_d = 1'b0;
                if (!MOSI)               state_d = WRITE;
                else if (!rd_addr_seen_q) state_d = READ_ADD;
                else                     state_d = READ_DATA;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (!word_done_q) begin
                    shreg_d = {shreg_q[WORD_W-3:0], MOSI};
                    if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                        rx_data_d   = {shreg_q, MOSI};
                        rx_valid_d  = 1'b1;
                        word_done_d = 1'b1;
                        bit_cnt_d   = '0;
                        if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (state_q == READ_DATA) begin
                    // First MISO bit goes out on the latch edge itself
                    if (!tx_started_q) begin
                        if (tx_valid) begin
                            tx_started_d   = 1'b1;
                            miso_d         = tx_data[DATA_W-1];
                            tx_shreg_d     = tx_data[DATA_W-2:0];
                            tx_cnt_d       = TXC_W'(DATA_W - 1);
                            rd_addr_seen_d = 1'b0;
                        end
                    end else if (tx_cnt_q != '0) begin
                        miso_d     = tx_shreg_q[DATA_W-2];
                        tx_shreg_d = {tx_shreg_q[DATA_W-3:0], 1'b0};
                        tx_cnt_d   = tx_cnt_q - TXC_W'(1);
                    end else begin
                        miso_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Deselect mid-frame drops the partial word but keeps rd_addr_seen
        if (SS_n && state_q != IDLE) begin
            state_d        = IDLE;
            bit_cnt_d      = '0;
            shreg_d        = '0;
            word_done_d    = 1'b0;
            tx_started_d   = 1'b0;
            tx_cnt_d       = '0;
            rx_data_d      = rx_data_q;
            rx_valid_d     = 1'b0;
            miso_d         = 1'b0;
            rd_addr_seen_d = rd_addr_seen_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            word_done_q    <= 1'b0;
            tx_started_q   <= 1'b0;
            tx_shreg_q     <= '0;
            tx_cnt_q       <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            word_done_q    <= word_done_d;
            tx_started_q   <= tx_started_d;
            tx_shreg_q     <= tx_shreg_d;
            tx_cnt_q       <= tx_cnt_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_q         <= miso_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: per-cycle expected {rx_valid, MISO, rx_data} queued by stimulus, checked by a negedge monitor.
module tb_spi_slave_if;

    logic       clk;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    spi_slave_if #(.WORD_W(10), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       vld;
        logic       miso;
        logic [9:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] exp_rx;
    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    int         cyc_no   = 0;

    // One clock edge; the outputs after it must match the given expectation
    task automatic cyc(input logic ev, input logic em);
        exp_t e;
        @(posedge clk);
        e.vld  = ev;
        e.miso = em;
        e.dat  = exp_rx;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic send_frame(input logic sel, input logic [9:0] w);
        ss_n = 1'b0; mosi = 1'b0;
        cyc(1'b0, 1'b0);
        mosi = sel;
        cyc(1'b0, 1'b0);
        for (int i = 9; i >= 1; i--) begin
            mosi = w[i];
            cyc(1'b0, 1'b0);
        end
        mosi   = w[0];
        exp_rx = w;
        cyc(1'b1, 1'b0);
        mosi = 1'b0;
    endtask

    task automatic end_frame;
        ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0;
        cyc(1'b0, 1'b0);
    endtask

    // RAM answers one cycle after rx_valid; em lists the MISO bits expected
    task automatic read_byte(input logic [7:0] b, input logic [7:0] em);
        cyc(1'b0, 1'b0);
        tx_valid = 1'b1; tx_data = b;
        cyc(1'b0, em[7]);
        tx_valid = 1'b0;
        for (int i = 6; i >= 0; i--) cyc(1'b0, em[i]);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_no++;
                chk_cnt++;
                if (rx_valid === e.vld) pass_cnt++;
                else $display("FAIL rx_valid cycle %0d: got %b expected %b", cyc_no, rx_valid, e.vld);
                chk_cnt++;
                if (miso === e.miso) pass_cnt++;
                else $display("FAIL miso cycle %0d: got %b expected %b", cyc_no, miso, e.miso);
                chk_cnt++;
                if (rx_data === e.dat) pass_cnt++;
                else $display("FAIL rx_data cycle %0d: got %h expected %h", cyc_no, rx_data, e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        exp_rx = 10'h000;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);

        // Write address, extra MOSI after the word is ignored
        send_frame(1'b0, 10'b00_1010_0101);
        mosi = 1'b1; cyc(1'b0, 1'b0);
        mosi = 1'b0; cyc(1'b0, 1'b0);
        end_frame();

        // Write data, then read address; stray tx_valid in READ_ADD ignored
        send_frame(1'b0, 10'h1C3);
        end_frame();
        send_frame(1'b1, 10'h2A5);
        tx_valid = 1'b1; tx_data = 8'hFF;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        end_frame();

        // Read data: C3 out on MISO, stray tx_valid mid-shift ignored
        send_frame(1'b1, 10'h300);
        cyc(1'b0, 1'b0);
        tx_valid = 1'b1; tx_data = 8'hC3;
        cyc(1'b0, 1'b1);
        tx_valid = 1'b0;
        cyc(1'b0, 1'b1);
        tx_valid = 1'b1; tx_data = 8'h00;
        cyc(1'b0, 1'b0);
        tx_valid = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        end_frame();

        // rd_addr_seen cleared: next 1-frame is a read address, MISO stays 0
        send_frame(1'b1, 10'h155);
        tx_valid = 1'b1; tx_data = 8'hFF;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        end_frame();

        // Stray tx_valid in IDLE and during a write frame
        tx_valid = 1'b1; tx_data = 8'hFF;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        send_frame(1'b0, 10'h0F0);
        cyc(1'b0, 1'b0);
        end_frame();

        // Abort after 5 word bits: no rx_valid, rx_data held
        ss_n = 1'b0; mosi = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            cyc(1'b0, 1'b0);
        end
        end_frame();
        send_frame(1'b0, 10'h3FF);
        end_frame();

        // Abort kept rd_addr_seen: read data, then reset during MISO shift
        send_frame(1'b1, 10'h2F0);
        cyc(1'b0, 1'b0);
        tx_valid = 1'b1; tx_data = 8'hA5;
        cyc(1'b0, 1'b1);
        tx_valid = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        rst_n = 1'b0; exp_rx = 10'h000;
        cyc(1'b0, 1'b0);
        rst_n = 1'b1; ss_n = 1'b1;
        cyc(1'b0, 1'b0);

        // Reset cleared rd_addr_seen: 1-frame is a read address again
        send_frame(1'b1, 10'h0AA);
        tx_valid = 1'b1; tx_data = 8'hFF;
        cyc(1'b0, 1'b0);
        tx_valid = 1'b0;
        cyc(1'b0, 1'b0);
        end_frame();
        send_frame(1'b1, 10'h011);
        read_byte(8'h81, 8'b1000_0001);
        end_frame();
        cyc(1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
